// File: rtl/spi_slave_xfer_ctrl.sv
// rtl/spi_slave_xfer_ctrl.sv - SPI slave transfer sequencer with TX/RX character FIFOs

// Character FIFO with a registered head word.
// A push while full and a pop while empty are ignored.
module spi_xfer_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                       S_SYSCLK,
  input  logic                       S_RESETN,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [AW:0] DEPTH_CNT = AW1'(DEPTH);
  localparam logic [AW:0] ONE_CNT   = AW1'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  head_q, head_d;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && (cnt_q != DEPTH_CNT);
  assign do_pop  = pop_i && (cnt_q != '0);
  assign rd_nxt  = rd_q + AW'(1);

  // Next pointers, occupancy and head word; the head tracks the entry that
  // will sit at the read pointer after this edge.
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    if (do_push) begin
      wr_d = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_nxt;
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + ONE_CNT;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - ONE_CNT;
    end
    if (do_pop) begin
      if (cnt_q == ONE_CNT) begin
        head_d = do_push ? push_data_i : '1;
      end else begin
        head_d = mem_q[rd_nxt];
      end
    end else if (do_push && (cnt_q == '0)) begin
      head_d = push_data_i;
    end
  end

  // Storage array; contents are don't-care once the pointers are reset.
  always_ff @(posedge S_SYSCLK) begin
    if (do_push) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

  // Pointer, occupancy and head registers.
  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '1;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  assign head_o  = head_q;
  assign level_o = cnt_q;

endmodule

// Top-level sequencer: mode shadowing, CS/done synchronisation, frame FSM.
module spi_slave_xfer_ctrl #(
  parameter int CHAR_NBITS = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  S_SYSCLK,
  input  logic                  S_RESETN,
  input  logic                  H_ENABLE,
  input  logic                  H_CPOL,
  input  logic                  H_CPHA,
  input  logic                  H_LOOP,
  input  logic                  H_REV,
  input  logic [3:0]            H_CHAR_LEN,
  input  logic                  H_TX_WR,
  input  logic [CHAR_NBITS-1:0] H_TX_DATA,
  output logic                  H_TX_FULL,
  output logic [6:0]            H_TX_LEVEL,
  input  logic                  H_RX_RD,
  output logic [CHAR_NBITS-1:0] H_RX_DATA,
  output logic                  H_RX_EMPTY,
  output logic [15:0]           H_FRAME_CNT,
  output logic                  H_EVT_FRAME,
  output logic                  H_EVT_UNDERRUN,
  output logic                  H_EVT_OVERFLOW,
  output logic                  H_BUSY,
  output logic                  T_ENABLE,
  output logic                  T_CPOL,
  output logic                  T_CPHA,
  output logic                  T_LOOP,
  output logic                  T_REV,
  output logic [3:0]            T_CHAR_LEN,
  output logic [CHAR_NBITS-1:0] T_WCHAR,
  input  logic [CHAR_NBITS-1:0] T_RCHAR,
  input  logic                  T_CHAR_DONE,
  input  logic                  T_SPI_CS
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [AW:0] DEPTH_CNT = AW1'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRELOAD,
    ST_ACTIVE,
    ST_ENDF
  } state_t;

  state_t                state_q;
  logic                  t_enable_q;
  logic                  t_cpol_q;
  logic                  t_cpha_q;
  logic                  t_loop_q;
  logic                  t_rev_q;
  logic [3:0]            t_char_len_q;
  logic [CHAR_NBITS-1:0] wchar_q;
  logic [15:0]           frame_cnt_q;
  logic                  evt_frame_q;
  logic                  evt_underrun_q;
  logic                  evt_overflow_q;

  logic                  cs_sync1_q;
  logic                  cs_sync2_q;
  logic                  cs_act_prev_q;
  logic                  done_sync1_q;
  logic                  done_sync2_q;
  logic                  done_sync3_q;
  logic                  done_evt_q;

  logic                  cs_act;
  logic                  cs_rise;
  logic                  char_slot;
  logic                  tx_pop;
  logic                  rx_push;
  logic [CHAR_NBITS-1:0] tx_head;
  logic [CHAR_NBITS-1:0] rx_head;
  logic [AW:0]           tx_level;
  logic [AW:0]           rx_level;
  logic                  tx_empty;
  logic                  rx_full;

  // Two-flop synchronisers for the pad CS and the transceiver done strobe,
  // plus edge-detect history; done_evt is registered one edge after sync.
  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      cs_sync1_q    <= 1'b1;
      cs_sync2_q    <= 1'b1;
      cs_act_prev_q <= 1'b0;
      done_sync1_q  <= 1'b0;
      done_sync2_q  <= 1'b0;
      done_sync3_q  <= 1'b0;
      done_evt_q    <= 1'b0;
    end else begin
      cs_sync1_q    <= T_SPI_CS;
      cs_sync2_q    <= cs_sync1_q;
      cs_act_prev_q <= cs_act;
      done_sync1_q  <= T_CHAR_DONE;
      done_sync2_q  <= done_sync1_q;
      done_sync3_q  <= done_sync2_q;
      done_evt_q    <= done_sync2_q && !done_sync3_q;
    end
  end

  assign cs_act   = !cs_sync2_q;
  assign cs_rise  = cs_act && !cs_act_prev_q;
  assign tx_empty = (tx_level == '0);
  assign rx_full  = (rx_level == DEPTH_CNT);

  // A character slot is the preload cycle or a completed character mid-frame;
  // each slot consumes one TX entry when one is available.
  assign char_slot = (state_q == ST_PRELOAD) || ((state_q == ST_ACTIVE) && done_evt_q);
  assign tx_pop    = char_slot && !tx_empty;
  assign rx_push   = (state_q == ST_ACTIVE) && done_evt_q;

  spi_xfer_fifo #(
    .W     (CHAR_NBITS),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .S_SYSCLK    (S_SYSCLK),
    .S_RESETN    (S_RESETN),
    .push_i      (H_TX_WR),
    .push_data_i (H_TX_DATA),
    .pop_i       (tx_pop),
    .head_o      (tx_head),
    .level_o     (tx_level)
  );

  spi_xfer_fifo #(
    .W     (CHAR_NBITS),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .S_SYSCLK    (S_SYSCLK),
    .S_RESETN    (S_RESETN),
    .push_i      (rx_push),
    .push_data_i (T_RCHAR),
    .pop_i       (H_RX_RD),
    .head_o      (rx_head),
    .level_o     (rx_level)
  );

  // Frame FSM: shadows host mode bits while idle, preloads/refills the TX
  // character, counts characters and raises one-cycle event pulses.
  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      state_q        <= ST_IDLE;
      t_enable_q     <= 1'b0;
      t_cpol_q       <= 1'b0;
      t_cpha_q       <= 1'b0;
      t_loop_q       <= 1'b0;
      t_rev_q        <= 1'b0;
      t_char_len_q   <= 4'd0;
      wchar_q        <= '1;
      frame_cnt_q    <= 16'd0;
      evt_frame_q    <= 1'b0;
      evt_underrun_q <= 1'b0;
      evt_overflow_q <= 1'b0;
    end else begin
      evt_frame_q    <= 1'b0;
      evt_underrun_q <= 1'b0;
      evt_overflow_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          t_enable_q   <= H_ENABLE;
          t_cpol_q     <= H_CPOL;
          t_cpha_q     <= H_CPHA;
          t_loop_q     <= H_LOOP;
          t_rev_q      <= H_REV;
          t_char_len_q <= H_CHAR_LEN;
          if (cs_rise && t_enable_q) begin
            state_q <= ST_PRELOAD;
          end
        end
        ST_PRELOAD: begin
          wchar_q        <= tx_empty ? '1 : tx_head;
          evt_underrun_q <= tx_empty;
          frame_cnt_q    <= 16'd0;
          state_q        <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          // The completed character is handled before CS release ends the frame.
          if (done_evt_q) begin
            wchar_q        <= tx_empty ? '1 : tx_head;
            evt_underrun_q <= tx_empty;
            evt_overflow_q <= rx_full;
            if (frame_cnt_q != 16'hFFFF) begin
              frame_cnt_q <= frame_cnt_q + 16'd1;
            end
          end
          if (!cs_act) begin
            state_q <= ST_ENDF;
          end
        end
        ST_ENDF: begin
          evt_frame_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign H_TX_FULL      = (tx_level == DEPTH_CNT);
  assign H_TX_LEVEL     = 7'(tx_level);
  assign H_RX_DATA      = rx_head;
  assign H_RX_EMPTY     = (rx_level == '0);
  assign H_FRAME_CNT    = frame_cnt_q;
  assign H_EVT_FRAME    = evt_frame_q;
  assign H_EVT_UNDERRUN = evt_underrun_q;
  assign H_EVT_OVERFLOW = evt_overflow_q;
  assign H_BUSY         = (state_q != ST_IDLE);
  assign T_ENABLE       = t_enable_q;
  assign T_CPOL         = t_cpol_q;
  assign T_CPHA         = t_cpha_q;
  assign T_LOOP         = t_loop_q;
  assign T_REV          = t_rev_q;
  assign T_CHAR_LEN     = t_char_len_q;
  assign T_WCHAR        = wchar_q;

endmodule

// File: tb/tb_spi_slave_xfer_ctrl.sv
// tb/tb_spi_slave_xfer_ctrl.sv - directed self-checking bench for spi_slave_xfer_ctrl
module tb_spi_slave_xfer_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        h_enable, h_cpol, h_cpha, h_loop, h_rev;
  logic [3:0]  h_char_len;
  logic        h_tx_wr;
  logic [31:0] h_tx_data;
  logic        h_tx_full;
  logic [6:0]  h_tx_level;
  logic        h_rx_rd;
  logic [31:0] h_rx_data;
  logic        h_rx_empty;
  logic [15:0] h_frame_cnt;
  logic        h_evt_frame, h_evt_underrun, h_evt_overflow, h_busy;
  logic        t_enable, t_cpol, t_cpha, t_loop, t_rev;
  logic [3:0]  t_char_len;
  logic [31:0] t_wchar;
  logic [31:0] t_rchar;
  logic        t_char_done;
  logic        t_spi_cs;

  int total = 0;
  int bad   = 0;
  int und_cnt = 0;
  int frm_cnt = 0;
  int ovf_cnt = 0;
  int und0, frm0, ovf0;

  always #5 clk = ~clk;

  spi_slave_xfer_ctrl dut (
    .S_SYSCLK       (clk),
    .S_RESETN       (rstn),
    .H_ENABLE       (h_enable),
    .H_CPOL         (h_cpol),
    .H_CPHA         (h_cpha),
    .H_LOOP         (h_loop),
    .H_REV          (h_rev),
    .H_CHAR_LEN     (h_char_len),
    .H_TX_WR        (h_tx_wr),
    .H_TX_DATA      (h_tx_data),
    .H_TX_FULL      (h_tx_full),
    .H_TX_LEVEL     (h_tx_level),
    .H_RX_RD        (h_rx_rd),
    .H_RX_DATA      (h_rx_data),
    .H_RX_EMPTY     (h_rx_empty),
    .H_FRAME_CNT    (h_frame_cnt),
    .H_EVT_FRAME    (h_evt_frame),
    .H_EVT_UNDERRUN (h_evt_underrun),
    .H_EVT_OVERFLOW (h_evt_overflow),
    .H_BUSY         (h_busy),
    .T_ENABLE       (t_enable),
    .T_CPOL         (t_cpol),
    .T_CPHA         (t_cpha),
    .T_LOOP         (t_loop),
    .T_REV          (t_rev),
    .T_CHAR_LEN     (t_char_len),
    .T_WCHAR        (t_wchar),
    .T_RCHAR        (t_rchar),
    .T_CHAR_DONE    (t_char_done),
    .T_SPI_CS       (t_spi_cs)
  );

  always @(negedge clk) begin
    if (h_evt_underrun) und_cnt <= und_cnt + 1;
    if (h_evt_frame)    frm_cnt <= frm_cnt + 1;
    if (h_evt_overflow) ovf_cnt <= ovf_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_push(input logic [31:0] d);
    h_tx_wr = 1'b1;
    h_tx_data = d;
    tick(1);
    h_tx_wr = 1'b0;
  endtask

  task automatic host_pop();
    h_rx_rd = 1'b1;
    tick(1);
    h_rx_rd = 1'b0;
  endtask

  task automatic xfer_char(input logic [31:0] rc);
    t_rchar = rc;
    t_char_done = 1'b1;
    tick(3);
    t_char_done = 1'b0;
    tick(3);
  endtask

  initial begin
    rstn = 1'b0;
    h_enable = 1'b0; h_cpol = 1'b0; h_cpha = 1'b0; h_loop = 1'b0; h_rev = 1'b0;
    h_char_len = 4'd0; h_tx_wr = 1'b0; h_tx_data = 32'd0; h_rx_rd = 1'b0;
    t_rchar = 32'd0; t_char_done = 1'b0; t_spi_cs = 1'b1;
    tick(2);
    chk("rst_wchar", t_wchar, 32'hFFFFFFFF);
    chk("rst_txlvl", h_tx_level, 32'd0);
    chk("rst_txfull", h_tx_full, 32'd0);
    chk("rst_rxempty", h_rx_empty, 32'd1);
    chk("rst_rxdata", h_rx_data, 32'hFFFFFFFF);
    chk("rst_busy", h_busy, 32'd0);
    chk("rst_fcnt", h_frame_cnt, 32'd0);
    chk("rst_tenable", t_enable, 32'd0);
    rstn = 1'b1;
    h_enable = 1'b1;
    tick(2);
    chk("idle_tenable", t_enable, 32'd1);

    // Mode 0 frame
    host_push(32'hA5A5A5A5);
    host_push(32'h0000FFFF);
    chk("m0_txlvl", h_tx_level, 32'd2);
    und0 = und_cnt; frm0 = frm_cnt;
    t_spi_cs = 1'b0;
    tick(3);
    chk("m0_busy_preload", h_busy, 32'd1);
    chk("m0_wchar_pre", t_wchar, 32'hFFFFFFFF);
    tick(1);
    chk("m0_wchar0", t_wchar, 32'hA5A5A5A5);
    chk("m0_txlvl1", h_tx_level, 32'd1);
    chk("m0_fcnt0", h_frame_cnt, 32'd0);
    xfer_char(32'h11111111);
    chk("m0_wchar1", t_wchar, 32'h0000FFFF);
    chk("m0_fcnt1", h_frame_cnt, 32'd1);
    chk("m0_rxdata1", h_rx_data, 32'h11111111);
    xfer_char(32'h22222222);
    chk("m0_wchar2", t_wchar, 32'hFFFFFFFF);
    chk("m0_underruns", und_cnt - und0, 32'd1);
    t_spi_cs = 1'b1;
    tick(6);
    chk("m0_busy_end", h_busy, 32'd0);
    chk("m0_frames", frm_cnt - frm0, 32'd1);
    chk("m0_fcnt2", h_frame_cnt, 32'd2);
    chk("m0_rxhead", h_rx_data, 32'h11111111);
    host_pop();
    chk("m0_rxsecond", h_rx_data, 32'h22222222);
    host_pop();
    chk("m0_rxdrained", h_rx_empty, 32'd1);

    // Config freeze
    t_spi_cs = 1'b0;
    tick(4);
    h_cpol = 1'b1; h_char_len = 4'd7;
    tick(2);
    chk("cf_cpol_frozen", t_cpol, 32'd0);
    chk("cf_len_frozen", t_char_len, 32'd0);
    t_spi_cs = 1'b1;
    tick(4);
    chk("cf_idle", h_busy, 32'd0);
    chk("cf_evtframe", h_evt_frame, 32'd1);
    chk("cf_cpol_still", t_cpol, 32'd0);
    tick(1);
    chk("cf_cpol_new", t_cpol, 32'd1);
    chk("cf_len_new", t_char_len, 32'd7);
    h_cpol = 1'b0; h_char_len = 4'd0;
    tick(2);

    // RX overflow
    ovf0 = ovf_cnt;
    t_spi_cs = 1'b0;
    tick(4);
    for (int i = 0; i < 9; i++) xfer_char(32'h100 + i);
    t_spi_cs = 1'b1;
    tick(6);
    chk("ov_events", ovf_cnt - ovf0, 32'd1);
    chk("ov_fcnt", h_frame_cnt, 32'd9);
    for (int i = 0; i < 8; i++) begin
      chk("ov_rxnotempty", h_rx_empty, 32'd0);
      chk("ov_rxdata", h_rx_data, 32'h100 + i);
      host_pop();
    end
    chk("ov_rxempty", h_rx_empty, 32'd1);

    // Simultaneous done and CS release
    t_spi_cs = 1'b0;
    tick(4);
    t_rchar = 32'h33333333;
    t_char_done = 1'b1;
    tick(1);
    t_spi_cs = 1'b1;
    tick(2);
    t_char_done = 1'b0;
    chk("sim_fcnt_before", h_frame_cnt, 32'd0);
    tick(1);
    chk("sim_fcnt", h_frame_cnt, 32'd1);
    chk("sim_rxpushed", h_rx_empty, 32'd0);
    chk("sim_endf_busy", h_busy, 32'd1);
    chk("sim_noframe_yet", h_evt_frame, 32'd0);
    tick(1);
    chk("sim_evtframe", h_evt_frame, 32'd1);
    chk("sim_idle", h_busy, 32'd0);
    chk("sim_rxdata", h_rx_data, 32'h33333333);
    host_pop();
    tick(2);

    // TX wrap with concurrent push/pop
    host_push(32'hC0000000);
    host_push(32'hC0000001);
    t_spi_cs = 1'b0;
    tick(4);
    chk("wr_wchar0", t_wchar, 32'hC0000000);
    chk("wr_lvl0", h_tx_level, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      t_rchar = k;
      t_char_done = 1'b1;
      tick(3);
      t_char_done = 1'b0;
      h_tx_wr = 1'b1;
      h_tx_data = 32'hC0000000 + k + 1;
      tick(1);
      h_tx_wr = 1'b0;
      tick(2);
      chk("wr_wchar", t_wchar, 32'hC0000000 + k);
      chk("wr_lvl", h_tx_level, 32'd1);
    end
    t_spi_cs = 1'b1;
    tick(6);

    // Reset mid-frame with 3 entries in each FIFO
    for (int i = 0; i < 5; i++) host_pop();
    host_push(32'hD0000000);
    host_push(32'hD0000001);
    t_spi_cs = 1'b0;
    tick(4);
    host_push(32'hD0000002);
    chk("rm_txlvl3", h_tx_level, 32'd3);
    chk("rm_busy", h_busy, 32'd1);
    chk("rm_rxnotempty", h_rx_empty, 32'd0);
    #1 rstn = 1'b0;
    #1;
    chk("rm_wchar", t_wchar, 32'hFFFFFFFF);
    chk("rm_txlvl", h_tx_level, 32'd0);
    chk("rm_rxempty", h_rx_empty, 32'd1);
    chk("rm_rxdata", h_rx_data, 32'hFFFFFFFF);
    chk("rm_busy0", h_busy, 32'd0);
    chk("rm_tenable", t_enable, 32'd0);
    chk("rm_fcnt", h_frame_cnt, 32'd0);
    t_spi_cs = 1'b1;
    tick(2);
    rstn = 1'b1;
    tick(2);
    chk("rm_after_busy", h_busy, 32'd0);
    chk("rm_after_txlvl", h_tx_level, 32'd0);

    // TX full boundary
    for (int i = 0; i < 9; i++) host_push(32'hE0 + i);
    chk("full_flag", h_tx_full, 32'd1);
    chk("full_lvl", h_tx_level, 32'd8);

    // Disabled: CS does not start a frame
    h_enable = 1'b0;
    tick(2);
    t_spi_cs = 1'b0;
    tick(6);
    chk("dis_idle", h_busy, 32'd0);
    t_spi_cs = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_xfer_ctrl.md
# spi_slave_xfer_ctrl

Sequencing controller for the SPI slave character transceiver. It holds the host-programmed mode configuration and applies it to the transceiver only between frames. It buffers transmit and receive characters in two FIFOs and pre-loads the next TX character. On each completed character it captures the received character and reports frame, underrun and overflow events to the host register block.

## Interface
Parameters:
- CHAR_NBITS, 32, character width; matches the transceiver.
- FIFO_DEPTH, 8, entries per FIFO; power of two, 2..64.

Ports:
- S_SYSCLK  in  1  platform clock.
- S_RESETN  in  1  reset: asynchronous, active-low; clock is S_SYSCLK.
- H_ENABLE, H_CPOL, H_CPHA, H_LOOP, H_REV  in  1 each  requested mode bits.
- H_CHAR_LEN  in  4  requested character length; 0 = 32 bits, else n+1.
- H_TX_WR  in  1  push H_TX_DATA into the TX FIFO.
- H_TX_DATA  in  CHAR_NBITS  TX character.
- H_TX_FULL  out  1  TX FIFO full.
- H_TX_LEVEL  out  7  TX FIFO occupancy.
- H_RX_RD  in  1  pop the RX FIFO.
- H_RX_DATA  out  CHAR_NBITS  RX FIFO head; valid while !H_RX_EMPTY.
- H_RX_EMPTY  out  1  RX FIFO empty.
- H_FRAME_CNT  out  16  characters completed in the current/last frame.
- H_EVT_FRAME, H_EVT_UNDERRUN, H_EVT_OVERFLOW  out  1 each  one-cycle event pulses.
- H_BUSY  out  1  frame in progress (state != IDLE).
- T_ENABLE, T_CPOL, T_CPHA, T_LOOP, T_REV  out  1 each  applied mode to the transceiver.
- T_CHAR_LEN  out  4  applied character length.
- T_WCHAR  out  CHAR_NBITS  character offered to the transceiver.
- T_RCHAR  in  CHAR_NBITS  character received by the transceiver.
- T_CHAR_DONE  in  1  transceiver done; asynchronous to S_SYSCLK.
- T_SPI_CS  in  1  raw chip select (active-low) from the pad; asynchronous.

## Operation
- **Synchronisers:** T_SPI_CS and T_CHAR_DONE each pass through a 2-flop synchroniser.
  - cs_act = !synced CS.
  - done_evt = rising edge of synced done (a third flop provides the edge detect).
- **FSM states:** IDLE, PRELOAD, ACTIVE, ENDF.
  - IDLE: every cycle, T_* mode outputs are loaded from the H_* inputs. On cs_act rise -> PRELOAD.
  - PRELOAD (1 cycle): T_WCHAR <= TX head and TX pops if the FIFO is non-empty. Otherwise T_WCHAR <= all-ones and H_EVT_UNDERRUN pulses. H_FRAME_CNT <= 0. Next state is ACTIVE.
  - ACTIVE: mode outputs are frozen. On done_evt:
    - Push T_RCHAR into the RX FIFO. If the RX FIFO is full, drop the character and pulse H_EVT_OVERFLOW.
    - Refill T_WCHAR using the same rule as PRELOAD, including the underrun pulse.
    - H_FRAME_CNT increments, saturating at 16'hFFFF.
    - On cs_act fall -> ENDF.
  - ENDF (1 cycle): pulse H_EVT_FRAME, then go to IDLE.
- **Simultaneous events:**
  - done_evt and cs_act fall in the same ACTIVE cycle: the character is processed first (push/refill/count), then the state moves to ENDF.
  - A done_evt detected in ENDF or IDLE is ignored.
- **FIFO rules:**
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - H_TX_WR while full is ignored. H_RX_RD while empty is ignored.
  - Pointers are AW = log2(FIFO_DEPTH) bits and wrap modulo the depth. Occupancy is AW+1 bits, zero-extended to 7 bits.
- **Enable:** T_ENABLE low in IDLE means the transceiver ignores the bus. The FSM still tracks CS but does not leave IDLE while T_ENABLE is 0.

## Timing
- **Reset values:**
  - T_* mode outputs: 0.
  - T_WCHAR: all-ones.
  - FIFOs: empty (H_TX_FULL=0, H_TX_LEVEL=0, H_RX_EMPTY=1).
  - H_RX_DATA: all-ones.
  - H_FRAME_CNT: 0; all events: 0; H_BUSY: 0.
  - State: IDLE.
- **Reset mid-frame:** all of the above apply immediately. Both FIFO contents are discarded.
- **CS detection latency:**
  - CS pad fall -> PRELOAD entered on the 3rd S_SYSCLK edge.
  - T_WCHAR valid at the 4th edge.
  - The SPI master must allow ≥4 S_SYSCLK periods of CS-to-first-SCK setup time.
- **Done detection latency:** T_CHAR_DONE rise -> done_evt on the 3rd edge; RX push and T_WCHAR refill take effect on the 4th edge.
- **Minimum spacing:** T_CHAR_DONE high and low phases each must be ≥2 S_SYSCLK periods to be detected.
- **Host FIFO ports:**
  - H_TX_FULL and H_RX_EMPTY update the cycle after the write/read edge.
  - H_RX_DATA is the registered head and updates on the same edge as the pop.
- **Event pulses:** exactly one S_SYSCLK cycle wide.

## Test plan
- **Mode 0 frame:** TX FIFO holds 0xA5A5A5A5, 0x0000FFFF; 2-character frame with T_RCHAR = 0x11111111, 0x22222222 on done -> T_WCHAR sequence A5A5A5A5, 0000FFFF, FFFFFFFF with one underrun pulse; RX FIFO reads 11111111, 22222222; H_FRAME_CNT = 2; one H_EVT_FRAME.
- **Config freeze:** change H_CPOL/H_CHAR_LEN=7 while ACTIVE -> T_CPOL/T_CHAR_LEN unchanged until the cycle after ENDF, then they take the new values.
- **RX overflow:** FIFO_DEPTH=8; 9 characters received with no H_RX_RD -> H_RX_EMPTY=0, 8 entries kept, one H_EVT_OVERFLOW, first 8 values intact.
- **Simultaneous done and CS rise:** done_evt and cs_act fall land in the same cycle -> character pushed, count incremented, then H_EVT_FRAME one cycle later.
- **FIFO wrap and concurrent push/pop:** fill/drain the TX FIFO 20 times with simultaneous H_TX_WR and pop -> data order preserved across pointer wrap; H_TX_LEVEL constant during concurrent cycles.
- **Reset mid-frame:** assert S_RESETN low during ACTIVE with 3 entries in each FIFO -> all outputs at reset values asynchronously; after release, state is IDLE and H_TX_LEVEL=0.
